// File: rtl/control_unit_pkg.sv
// Shared encodings for the 8-bit CPU controller: opcodes, select codes,
// CCR bit positions, state encoding and the control-word payload.
package control_unit_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CCR_W   = 4;
  localparam int unsigned STATE_W = 5;

  localparam logic [OP_W-1:0] OP_LDA_IMM = 8'h86;
  localparam logic [OP_W-1:0] OP_LDA_DIR = 8'h87;
  localparam logic [OP_W-1:0] OP_LDB_IMM = 8'h88;
  localparam logic [OP_W-1:0] OP_LDB_DIR = 8'h89;
  localparam logic [OP_W-1:0] OP_STA_DIR = 8'h96;
  localparam logic [OP_W-1:0] OP_STB_DIR = 8'h97;
  localparam logic [OP_W-1:0] OP_ADD_AB  = 8'h42;
  localparam logic [OP_W-1:0] OP_SUB_AB  = 8'h43;
  localparam logic [OP_W-1:0] OP_AND_AB  = 8'h44;
  localparam logic [OP_W-1:0] OP_OR_AB   = 8'h45;
  localparam logic [OP_W-1:0] OP_INCA    = 8'h46;
  localparam logic [OP_W-1:0] OP_DECA    = 8'h48;
  localparam logic [OP_W-1:0] OP_NOTA    = 8'h4A;
  localparam logic [OP_W-1:0] OP_BRA     = 8'h20;
  localparam logic [OP_W-1:0] OP_BMI     = 8'h21;
  localparam logic [OP_W-1:0] OP_BPL     = 8'h22;
  localparam logic [OP_W-1:0] OP_BEQ     = 8'h23;
  localparam logic [OP_W-1:0] OP_BNE     = 8'h24;
  localparam logic [OP_W-1:0] OP_BVS     = 8'h25;
  localparam logic [OP_W-1:0] OP_BVC     = 8'h26;
  localparam logic [OP_W-1:0] OP_BCS     = 8'h27;
  localparam logic [OP_W-1:0] OP_BCC     = 8'h28;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALU_W-1:0] ALU_INCA = 3'b100;
  localparam logic [ALU_W-1:0] ALU_DECA = 3'b101;
  localparam logic [ALU_W-1:0] ALU_NOTA = 3'b111;

  localparam logic [SEL_W-1:0] B1_PC   = 2'b00;
  localparam logic [SEL_W-1:0] B1_A    = 2'b01;
  localparam logic [SEL_W-1:0] B1_B    = 2'b10;
  localparam logic [SEL_W-1:0] B2_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] B2_BUS1 = 2'b01;
  localparam logic [SEL_W-1:0] B2_MEM  = 2'b10;

  localparam int unsigned CCR_N = 3;
  localparam int unsigned CCR_Z = 2;
  localparam int unsigned CCR_V = 1;
  localparam int unsigned CCR_C = 0;

  localparam logic [STATE_W-1:0] S_F0 = 5'd0;
  localparam logic [STATE_W-1:0] S_F1 = 5'd1;
  localparam logic [STATE_W-1:0] S_F2 = 5'd2;
  localparam logic [STATE_W-1:0] S_D3 = 5'd3;
  localparam logic [STATE_W-1:0] S_E4 = 5'd4;
  localparam logic [STATE_W-1:0] S_E5 = 5'd5;
  localparam logic [STATE_W-1:0] S_E6 = 5'd6;
  localparam logic [STATE_W-1:0] S_E7 = 5'd7;

  typedef enum logic [2:0] {
    CLS_ILL, CLS_ALU, CLS_BR, CLS_LD_IMM, CLS_LD_DIR, CLS_ST_DIR
  } op_class_t;

  typedef struct packed {
    logic             ir_load;
    logic             mar_load;
    logic             pc_load;
    logic             pc_inc;
    logic             a_load;
    logic             b_load;
    logic             ccr_load;
    logic [ALU_W-1:0] alu_sel;
    logic [SEL_W-1:0] bus1_sel;
    logic [SEL_W-1:0] bus2_sel;
    logic             write;
    logic             illegal;
  } ctrl_t;

  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB,
      OP_INCA, OP_DECA, OP_NOTA:              return CLS_ALU;
      OP_BRA, OP_BMI, OP_BPL, OP_BEQ, OP_BNE,
      OP_BVS, OP_BVC, OP_BCS, OP_BCC:         return CLS_BR;
      OP_LDA_IMM, OP_LDB_IMM:                 return CLS_LD_IMM;
      OP_LDA_DIR, OP_LDB_DIR:                 return CLS_LD_DIR;
      OP_STA_DIR, OP_STB_DIR:                 return CLS_ST_DIR;
      default:                                return CLS_ILL;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_code(input logic [OP_W-1:0] op);
    case (op)
      OP_AND_AB: return ALU_AND;
      OP_SUB_AB: return ALU_SUB;
      OP_OR_AB:  return ALU_OR;
      OP_INCA:   return ALU_INCA;
      OP_DECA:   return ALU_DECA;
      OP_NOTA:   return ALU_NOTA;
      default:   return ALU_ADD;
    endcase
  endfunction

  // Loads/stores whose register operand is A rather than B.
  function automatic logic uses_a(input logic [OP_W-1:0] op);
    return (op == OP_LDA_IMM) || (op == OP_LDA_DIR) || (op == OP_STA_DIR);
  endfunction

endpackage

// File: rtl/control_unit_branch_eval.sv
// Branch condition evaluator: decides taken/not-taken from opcode and CCR.
module branch_eval
  import control_unit_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  input  logic [CCR_W-1:0] ccr,
  output logic             taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BRA:  taken = 1'b1;
      OP_BMI:  taken = ccr[CCR_N];
      OP_BPL:  taken = ~ccr[CCR_N];
      OP_BEQ:  taken = ccr[CCR_Z];
      OP_BNE:  taken = ~ccr[CCR_Z];
      OP_BVS:  taken = ccr[CCR_V];
      OP_BVC:  taken = ~ccr[CCR_V];
      OP_BCS:  taken = ccr[CCR_C];
      OP_BCC:  taken = ~ccr[CCR_C];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the 8-bit CPU: fetch, decode and execute strobes for data_path.
module control_unit
  import control_unit_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [OP_W-1:0]  IR_out,
  input  logic [CCR_W-1:0] CCR_Result,
  output logic             IR_Load,
  output logic             MAR_Load,
  output logic             PC_Load,
  output logic             PC_Inc,
  output logic             A_Load,
  output logic             B_Load,
  output logic             CCR_Load,
  output logic [ALU_W-1:0] ALU_Sel,
  output logic [SEL_W-1:0] Bus1_Sel,
  output logic [SEL_W-1:0] Bus2_Sel,
  output logic             write,
  output logic             Illegal
);

  logic [STATE_W-1:0] state, next_state;
  ctrl_t              ctrl, ctrl_gated;
  op_class_t          cls;
  logic               taken;
  logic               sel_a;

  assign cls   = op_class(IR_out);
  assign sel_a = uses_a(IR_out);

  branch_eval u_branch_eval (
    .opcode (IR_out),
    .ccr    (CCR_Result),
    .taken  (taken)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_F0;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_F0;
    ctrl       = '0;
    case (state)
      S_F0: begin
        ctrl.bus1_sel = B1_PC;
        ctrl.bus2_sel = B2_BUS1;
        ctrl.mar_load = 1'b1;
        next_state    = S_F1;
      end
      S_F1: begin
        ctrl.pc_inc = 1'b1;
        next_state  = S_F2;
      end
      S_F2: begin
        ctrl.bus2_sel = B2_MEM;
        ctrl.ir_load  = 1'b1;
        next_state    = S_D3;
      end
      S_D3: begin
        if (cls == CLS_ILL) begin
          ctrl.illegal = 1'b1;
          next_state   = S_F0;
        end else begin
          next_state   = S_E4;
        end
      end
      // ALU ops finish here; everything else latches the operand address.
      S_E4: begin
        if (cls == CLS_ALU) begin
          ctrl.alu_sel  = alu_code(IR_out);
          ctrl.bus1_sel = B1_A;
          ctrl.bus2_sel = B2_ALU;
          ctrl.a_load   = 1'b1;
          ctrl.ccr_load = 1'b1;
          next_state    = S_F0;
        end else begin
          ctrl.bus1_sel = B1_PC;
          ctrl.bus2_sel = B2_BUS1;
          ctrl.mar_load = 1'b1;
          next_state    = S_E5;
        end
      end
      S_E5: begin
        if (cls == CLS_BR) begin
          if (taken) begin
            ctrl.bus2_sel = B2_MEM;
            ctrl.pc_load  = 1'b1;
          end else begin
            ctrl.pc_inc   = 1'b1;
          end
          next_state = S_F0;
        end else begin
          ctrl.pc_inc = 1'b1;
          next_state  = S_E6;
        end
      end
      S_E6: begin
        ctrl.bus2_sel = B2_MEM;
        if (cls == CLS_LD_IMM) begin
          ctrl.a_load = sel_a;
          ctrl.b_load = ~sel_a;
          next_state  = S_F0;
        end else begin
          ctrl.mar_load = 1'b1;
          next_state    = S_E7;
        end
      end
      S_E7: begin
        if (cls == CLS_LD_DIR) begin
          ctrl.bus2_sel = B2_MEM;
          ctrl.a_load   = sel_a;
          ctrl.b_load   = ~sel_a;
        end else begin
          ctrl.bus1_sel = sel_a ? B1_A : B1_B;
          ctrl.write    = 1'b1;
        end
        next_state = S_F0;
      end
      default: next_state = S_F0;
    endcase
  end

  // Reset forces every strobe low, so an abandoned instruction cannot write.
  assign ctrl_gated = Reset ? '0 : ctrl;

  assign IR_Load  = ctrl_gated.ir_load;
  assign MAR_Load = ctrl_gated.mar_load;
  assign PC_Load  = ctrl_gated.pc_load;
  assign PC_Inc   = ctrl_gated.pc_inc;
  assign A_Load   = ctrl_gated.a_load;
  assign B_Load   = ctrl_gated.b_load;
  assign CCR_Load = ctrl_gated.ccr_load;
  assign ALU_Sel  = ctrl_gated.alu_sel;
  assign Bus1_Sel = ctrl_gated.bus1_sel;
  assign Bus2_Sel = ctrl_gated.bus2_sel;
  assign write    = ctrl_gated.write;
  assign Illegal  = ctrl_gated.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed per-cycle check of the controller's strobe word for each instruction class.
module tb_control_unit;

  logic       Clk, Reset;
  logic [7:0] IR_out;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       write, Illegal;
  logic [15:0] out_word;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .Clk(Clk), .Reset(Reset), .IR_out(IR_out), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write), .Illegal(Illegal)
  );

  // {IR,MAR,PCL,PCI,A,B,CCR, ALU[3], BUS1[2], BUS2[2], write, Illegal}
  assign out_word = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                     ALU_Sel, Bus1_Sel, Bus2_Sel, write, Illegal};

  localparam logic [15:0] W_ZERO = 16'h0000;
  localparam logic [15:0] W_F0   = {7'b0100000, 3'b000, 2'b00, 2'b01, 2'b00};
  localparam logic [15:0] W_F1   = {7'b0001000, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] W_F2   = {7'b1000000, 3'b000, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] W_D3   = 16'h0000;
  localparam logic [15:0] W_ILL  = 16'h0001;
  localparam logic [15:0] W_LDA  = {7'b0000100, 3'b000, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] W_LDB  = {7'b0000010, 3'b000, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] W_MARM = {7'b0100000, 3'b000, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] W_STA  = {7'b0000000, 3'b000, 2'b01, 2'b00, 2'b10};
  localparam logic [15:0] W_STB  = {7'b0000000, 3'b000, 2'b10, 2'b00, 2'b10};
  localparam logic [15:0] W_BT   = {7'b0010000, 3'b000, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] W_BN   = W_F1;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic test_reset();
    Reset = 1'b1; IR_out = 8'h00; CCR_Result = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      checks++;
      if (out_word !== W_ZERO) begin
        errors++; $display("FAIL reset_hold cyc %0d: got %h expected %h", i, out_word, W_ZERO);
      end
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_alu_ops();
    logic [7:0]  ops  [7] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h48, 8'h4A};
    logic [2:0]  alus [7] = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b101, 3'b111};
    logic [15:0] seq  [5];
    for (int k = 0; k < 7; k++) begin
      IR_out = ops[k];
      seq = '{W_F0, W_F1, W_F2, W_D3, {7'b0000101, alus[k], 2'b01, 2'b00, 2'b00}};
      for (int i = 0; i < 5; i++) begin
        #1; checks++;
        if (out_word !== seq[i]) begin
          errors++; $display("FAIL alu op %h cyc %0d: got %h expected %h", ops[k], i, out_word, seq[i]);
        end
        @(negedge Clk);
      end
    end
  endtask

  task automatic test_imm_load(input logic [7:0] op, input logic [15:0] last);
    logic [15:0] seq [7];
    IR_out = op;
    seq = '{W_F0, W_F1, W_F2, W_D3, W_F0, W_F1, last};
    for (int i = 0; i < 7; i++) begin
      #1; checks++;
      if (out_word !== seq[i]) begin
        errors++; $display("FAIL imm_load %h cyc %0d: got %h expected %h", op, i, out_word, seq[i]);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_direct(input logic [7:0] op, input logic [15:0] last);
    logic [15:0] seq [8];
    IR_out = op;
    seq = '{W_F0, W_F1, W_F2, W_D3, W_F0, W_F1, W_MARM, last};
    for (int i = 0; i < 8; i++) begin
      #1; checks++;
      if (out_word !== seq[i]) begin
        errors++; $display("FAIL direct %h cyc %0d: got %h expected %h", op, i, out_word, seq[i]);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_branch(input logic [7:0] op, input logic [3:0] ccr, input logic tk);
    logic [15:0] seq [6];
    IR_out = op; CCR_Result = ccr;
    seq = '{W_F0, W_F1, W_F2, W_D3, W_F0, (tk ? W_BT : W_BN)};
    for (int i = 0; i < 6; i++) begin
      #1; checks++;
      if (out_word !== seq[i]) begin
        errors++; $display("FAIL branch %h ccr %b cyc %0d: got %h expected %h", op, ccr, i, out_word, seq[i]);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_illegal(input logic [7:0] op);
    logic [15:0] seq [4];
    IR_out = op;
    seq = '{W_F0, W_F1, W_F2, W_ILL};
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (out_word !== seq[i]) begin
        errors++; $display("FAIL illegal %h cyc %0d: got %h expected %h", op, i, out_word, seq[i]);
      end
      @(negedge Clk);
    end
  endtask

  // Reset lands during E6 of LDA_DIR; the abandoned load must never assert A_Load.
  task automatic test_reset_mid();
    logic [15:0] seq [7];
    IR_out = 8'h87;
    seq = '{W_F0, W_F1, W_F2, W_D3, W_F0, W_F1, W_MARM};
    for (int i = 0; i < 7; i++) begin
      #1; checks++;
      if (out_word !== seq[i]) begin
        errors++; $display("FAIL reset_mid pre cyc %0d: got %h expected %h", i, out_word, seq[i]);
      end
      if (i < 6) @(negedge Clk);
    end
    Reset = 1'b1;
    #1; checks++;
    if (out_word !== W_ZERO) begin
      errors++; $display("FAIL reset_mid hold: got %h expected %h", out_word, W_ZERO);
    end
    @(negedge Clk); #1; checks++;
    if (out_word !== W_ZERO) begin
      errors++; $display("FAIL reset_mid hold2: got %h expected %h", out_word, W_ZERO);
    end
    @(negedge Clk);
    Reset = 1'b0;
    IR_out = 8'hFF;
    seq = '{W_F0, W_F1, W_F2, W_ILL, W_F0, W_F0, W_F0};
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (out_word !== seq[i] || A_Load !== 1'b0) begin
        errors++; $display("FAIL reset_mid post cyc %0d: got %h expected %h", i, out_word, seq[i]);
      end
      if (i < 4) @(negedge Clk);
    end
    @(negedge Clk);
    IR_out = 8'hFF;
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_imm_load(8'h86, W_LDA);
    test_imm_load(8'h88, W_LDB);
    test_direct(8'h87, W_LDA);
    test_direct(8'h89, W_LDB);
    test_direct(8'h96, W_STA);
    test_direct(8'h97, W_STB);
    test_branch(8'h23, 4'b0000, 1'b0);
    test_branch(8'h23, 4'b0100, 1'b1);
    test_branch(8'h20, 4'b0000, 1'b1);
    test_branch(8'h21, 4'b1000, 1'b1);
    test_branch(8'h22, 4'b1000, 1'b0);
    test_branch(8'h24, 4'b0000, 1'b1);
    test_branch(8'h24, 4'b0100, 1'b0);
    test_branch(8'h25, 4'b0010, 1'b1);
    test_branch(8'h26, 4'b0010, 1'b0);
    test_branch(8'h27, 4'b0001, 1'b1);
    test_branch(8'h28, 4'b0001, 1'b0);
    test_branch(8'h28, 4'b1110, 1'b1);
    test_illegal(8'hFF);
    test_illegal(8'h47);
    test_illegal(8'h29);
    test_direct(8'h89, W_LDB);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
